// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v counters,
// and a registered decode of sync, active-video, coordinates and line/frame strobes.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          pix_tick,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if ((2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_cw_check
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [DW-1:0] div;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          evt;
  logic          hs_d, vs_d, act_d, ls_d, fs_d;

  assign pix_tick = en && (div == DIV_LAST);

  // Stage p0: divider and raster counters; evt marks a freshly changed position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      evt   <= 1'b1;
    end else if (en) begin
      evt <= pix_tick;
      if (pix_tick) begin
        div <= '0;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_comb begin
    hs_d  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_d  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    act_d = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    ls_d  = evt && (h_cnt == '0);
    fs_d  = evt && (h_cnt == '0) && (v_cnt == '0);
  end

  // Stage p1: registered decode; strobes only fire once per new position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hs          <= hs_d ? HS_POL : ~HS_POL;
      vs          <= vs_d ? VS_POL : ~VS_POL;
      active      <= act_d;
      x           <= act_d ? h_cnt : '0;
      y           <= act_d ? v_cnt : '0;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance and a tiny raster instance,
// checked cycle by cycle against an arithmetic raster-position model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int DA = 4;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn_a, en_a, rn_b, en_b;
  logic pt_a, hs_a, vs_a, act_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic pt_b, hs_b, vs_b, act_b, ls_b, fs_b;
  logic [3:0] x_b, y_b;

  vga_timing_gen u_a (
    .clk(clk), .reset_n(rn_a), .en(en_a), .pix_tick(pt_a), .hs(hs_a), .vs(vs_a),
    .active(act_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) u_b (
    .clk(clk), .reset_n(rn_b), .en(en_b), .pix_tick(pt_b), .hs(hs_b), .vs(vs_b),
    .active(act_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  logic [31:0] obs_a, obs_b;
  assign obs_a = {pt_a, hs_a, vs_a, act_a, ls_a, fs_a, 6'd0, x_a, y_a};
  assign obs_b = {pt_b, hs_b, vs_b, act_b, ls_b, fs_b, 6'd0, 6'd0, x_b, 6'd0, y_b};

  localparam logic [31:0] RST_A = 32'h6000_0000;
  localparam logic [31:0] RST_B = 32'h0000_0000;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ea = 0;
  int eb = 0;
  logic [31:0] last_a = RST_A;
  logic [31:0] last_b = RST_B;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  // Output word expected after the e-th enabled clock since reset release
  function automatic logic [31:0] model(int e, int d, int ha, int hf, int hsw, int hb,
                                        int va, int vf, int vsw, int vb, bit hp, bit vp);
    int p, h, v, ht, vt;
    logic [31:0] w;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = (e - 1) / d;
    h  = p % ht;
    v  = (p / ht) % vt;
    w  = '0;
    w[30] = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    w[29] = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    w[28] = (h < ha) && (v < va);
    w[27] = (((e - 1) % d) == 0) && (h == 0);
    w[26] = w[27] && (v == 0);
    if (w[28]) begin
      w[19:10] = 10'(h);
      w[9:0]   = 10'(v);
    end
    return w;
  endfunction

  task automatic step(input logic a_en, input logic a_rn, input logic b_en,
                      input logic b_rn, input bit sel);
    logic pa, pb;
    en_a = a_en; rn_a = a_rn; en_b = b_en; rn_b = b_rn;
    @(posedge clk);
    cyc++;
    if (!rn_a) begin ea = 0; last_a = RST_A; end
    else if (en_a) begin ea++; last_a = model(ea, DA, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0); end
    else last_a[27:26] = 2'b00;
    if (!rn_b) begin eb = 0; last_b = RST_B; end
    else if (en_b) begin eb++; last_b = model(eb, DB, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1); end
    else last_b[27:26] = 2'b00;
    pa = en_a && ((ea % DA) == DA - 1);
    pb = en_b && ((eb % DB) == DB - 1);
    if (sel) qb.push_back({pb, last_b[30:0]});
    else     qa.push_back({pa, last_a[30:0]});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] want;
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL reset_hold cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
    end
    checks++;
    if (hs_a !== 1'b1 || vs_a !== 1'b1 || act_a !== 1'b0 || x_a !== 10'd0 || y_a !== 10'd0) begin
      failures++; $display("FAIL reset_values got=%08h want=%08h", obs_a, RST_A);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL reset_en0 cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
      if (pt_a) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("FAIL reset_no_tick got=%0d want=0", pulses); end
  endtask

  task automatic test_horizontal();
    logic [31:0] want;
    int last_ls = -1, hs_low = 0, act_n = 0, pt_n = 0, lines = 0, xmax = 0;
    for (int i = 0; i < 3 * 3200 + 50; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL hline_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
      if (ls_a) begin
        if (last_ls >= 0) begin
          lines++;
          checks++;
          if (cyc - last_ls != 3200) begin failures++; $display("FAIL line_period got=%0d want=3200", cyc - last_ls); end
          checks++;
          if (hs_low != 384) begin failures++; $display("FAIL hs_width got=%0d want=384", hs_low); end
          checks++;
          if (act_n != 2560) begin failures++; $display("FAIL active_width got=%0d want=2560", act_n); end
          checks++;
          if (pt_n != 800) begin failures++; $display("FAIL tick_count got=%0d want=800", pt_n); end
        end
        last_ls = cyc; hs_low = 0; act_n = 0; pt_n = 0;
      end
      if (!hs_a) hs_low++;
      if (act_a) act_n++;
      if (pt_a) pt_n++;
      if (act_a && int'(x_a) > xmax) xmax = int'(x_a);
    end
    checks++;
    if (lines != 3) begin failures++; $display("FAIL line_count got=%0d want=3", lines); end
    checks++;
    if (xmax != 639) begin failures++; $display("FAIL x_max got=%0d want=639", xmax); end
  endtask

  task automatic test_stall();
    logic [31:0] want;
    logic [9:0] prev_x = 10'h3ff;
    logic hs_s;
    bit found = 0;
    int n = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL seek_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
      if (act_a && x_a == 10'd100 && prev_x != 10'd100) found = 1;
      prev_x = x_a;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL seek_x100 got=timeout want=x100"); end
    hs_s = hs_a;
    for (int i = 0; i < 37; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL stall_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
      checks++;
      if (x_a !== 10'd100 || act_a !== 1'b1 || hs_a !== hs_s) begin
        failures++; $display("FAIL stall_freeze got=x%0d act%0b hs%0b want=x100 act1 hs%0b", x_a, act_a, hs_a, hs_s);
      end
    end
    for (int i = 0; i < 8 && x_a == 10'd100; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL resume_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
      n++;
    end
    checks++;
    if (x_a !== 10'd101 || n != 4) begin failures++; $display("FAIL resume_next got=x%0d after %0d want=x101 after 4", x_a, n); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] want;
    rn_a = 1'b0;
    #1;
    checks++;
    if (obs_a !== RST_A) begin failures++; $display("FAIL async_reset got=%08h want=%08h", obs_a, RST_A); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL inreset_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    want = qa.pop_front(); checks++;
    if (obs_a !== want) begin failures++; $display("FAIL release_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
    checks++;
    if (fs_a !== 1'b1 || ls_a !== 1'b1 || act_a !== 1'b1 || x_a !== 10'd0 || y_a !== 10'd0) begin
      failures++; $display("FAIL release_frame_start got=%08h want=frame_start at 0,0", obs_a);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL postrel_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
    end
  endtask

  task automatic test_small();
    logic [31:0] want;
    int last_ls = -1, last_fs = -1, hs_hi = 0, vs_hi = 0, frames = 0, xmax = 0, ymax = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      want = qb.pop_front(); checks++;
      if (obs_b !== want) begin failures++; $display("FAIL small_reset_sb cyc=%0d got=%08h want=%08h", cyc, obs_b, want); end
    end
    for (int i = 0; i < 4 * 84 + 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      want = qb.pop_front(); checks++;
      if (obs_b !== want) begin failures++; $display("FAIL small_sb cyc=%0d got=%08h want=%08h", cyc, obs_b, want); end
      if (ls_b) begin
        if (last_ls >= 0) begin
          checks++;
          if (cyc - last_ls != 12) begin failures++; $display("FAIL small_line_period got=%0d want=12", cyc - last_ls); end
          checks++;
          if (hs_hi != 2) begin failures++; $display("FAIL small_hs_width got=%0d want=2", hs_hi); end
        end
        last_ls = cyc; hs_hi = 0;
      end
      if (fs_b) begin
        if (last_fs >= 0) begin
          frames++;
          checks++;
          if (cyc - last_fs != 84) begin failures++; $display("FAIL small_frame_period got=%0d want=84", cyc - last_fs); end
          checks++;
          if (vs_hi != 12) begin failures++; $display("FAIL small_vs_width got=%0d want=12", vs_hi); end
        end
        last_fs = cyc; vs_hi = 0;
      end
      if (hs_b) hs_hi++;
      if (vs_b) vs_hi++;
      if (act_b && int'(x_b) > xmax) xmax = int'(x_b);
      if (act_b && int'(y_b) > ymax) ymax = int'(y_b);
    end
    checks++;
    if (frames != 4) begin failures++; $display("FAIL small_frames got=%0d want=4", frames); end
    checks++;
    if (xmax != 7 || ymax != 3) begin failures++; $display("FAIL small_xy_max got=%0d,%0d want=7,3", xmax, ymax); end
  endtask

  task automatic test_random_en();
    logic [31:0] want;
    logic e;
    for (int i = 0; i < 500; i++) begin
      e = ($urandom_range(0, 3) != 0);
      step(1'b0, 1'b0, e, 1'b1, 1'b1);
      want = qb.pop_front(); checks++;
      if (obs_b !== want) begin failures++; $display("FAIL rand_small_sb cyc=%0d got=%08h want=%08h", cyc, obs_b, want); end
    end
    for (int i = 0; i < 1500; i++) begin
      e = ($urandom_range(0, 2) != 0);
      step(e, 1'b1, 1'b0, 1'b1, 1'b0);
      want = qa.pop_front(); checks++;
      if (obs_a !== want) begin failures++; $display("FAIL rand_dflt_sb cyc=%0d got=%08h want=%08h", cyc, obs_a, want); end
    end
  endtask

  initial begin
    rn_a = 1'b0; en_a = 1'b0; rn_b = 1'b0; en_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_horizontal();
    test_stall();
    test_reset_mid();
    test_small();
    test_random_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
